// File: rtl/memory_arbiter.sv
// ============================================================================
// Module   : memory_arbiter
// Brief    : Shares the single-port Hack data memory between the CPU data port
//            and the display scan-out reader, with bounded video bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter #(
    parameter int          VID_BURST   = 4,
    parameter logic [14:0] SCREEN_BASE = 15'h4000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    output logic        cpu_werr,

    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_gnt,
    output logic        vid_rvalid,
    output logic [15:0] vid_rdata,

    output logic [15:0] mem_in,
    output logic [14:0] mem_address,
    output logic        mem_load,
    input  logic [15:0] mem_out
);

    localparam logic [3:0]  c_BURST       = 4'(VID_BURST);
    localparam logic [14:0] c_WRITE_LIMIT = 15'h6000;

    logic [3:0]  r_vid_run;
    logic        w_burst_done;
    logic        w_write_ok;
    logic        w_cpu_read;
    logic        w_cpu_blocked;
    logic [14:0] w_vid_address;

    assign w_burst_done  = (r_vid_run == c_BURST);
    assign w_write_ok    = (cpu_addr < c_WRITE_LIMIT);
    assign w_vid_address = SCREEN_BASE + {2'b00, vid_addr};

    // Video normally wins a contested cycle; the CPU wins once video has
    // taken VID_BURST grants in a row while the CPU was waiting.
    always_comb begin
        cpu_gnt = 1'b0;
        vid_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && vid_req) begin
                if (w_burst_done) begin
                    cpu_gnt = 1'b1;
                end else begin
                    vid_gnt = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (vid_req) begin
                vid_gnt = 1'b1;
            end
        end
    end

    assign w_cpu_read    = cpu_gnt & ~cpu_we;
    assign w_cpu_blocked = cpu_gnt &  cpu_we & ~w_write_ok;

    always_comb begin
        mem_address = cpu_addr;
        mem_in      = cpu_wdata;
        if (vid_gnt) begin
            mem_address = w_vid_address;
            mem_in      = 16'h0000;
        end
    end

    assign mem_load = cpu_gnt & cpu_we & w_write_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vid_run <= 4'd0;
        end else if (cpu_gnt || !cpu_req) begin
            r_vid_run <= 4'd0;
        end else if (vid_gnt && !w_burst_done) begin
            r_vid_run <= r_vid_run + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 16'h0000;
            cpu_werr   <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_rdata  <= 16'h0000;
        end else begin
            cpu_rvalid <= w_cpu_read;
            cpu_werr   <= w_cpu_blocked;
            vid_rvalid <= vid_gnt;
            if (w_cpu_read) begin
                cpu_rdata <= mem_out;
            end
            if (vid_gnt) begin
                vid_rdata <= mem_out;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Randomized scoreboard bench for memory_arbiter with a behavioural
//            memory and arbitration reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

    localparam int          c_BURST = 4;
    localparam logic [14:0] c_BASE  = 15'h4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, cpu_werr;
    logic [15:0] cpu_rdata;
    logic        vid_req = 1'b0;
    logic [12:0] vid_addr = '0;
    logic        vid_gnt, vid_rvalid;
    logic [15:0] vid_rdata;
    logic [15:0] mem_in;
    logic [14:0] mem_address;
    logic        mem_load;
    logic [15:0] mem_out;

    memory_arbiter #(.VID_BURST(c_BURST), .SCREEN_BASE(c_BASE)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .cpu_werr(cpu_werr),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // Physical memory the DUT drives, and the model's view of what it should hold.
    logic [15:0] bmem [32768];
    logic [15:0] mm   [32768];
    assign mem_out = bmem[mem_address];
    always @(posedge clk) if (mem_load) bmem[mem_address] <= mem_in;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] cpu_q [$];
    logic [15:0] vid_q [$];
    int          werr_q [$];
    int          cpu_wait_grants = 0;
    logic        exp_cg, exp_vg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, predict, check combinational outputs, update model.
    task automatic cycle(input logic cr, input logic cw, input logic [14:0] ca,
                         input logic [15:0] cd, input logic vr, input logic [12:0] va,
                         input logic rs);
        logic [14:0] vfull;
        @(posedge clk);
        #3;
        reset = rs; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        vid_req = vr; vid_addr = va;
        #2;
        vfull = 15'((32'(c_BASE) + 32'(va)) % 32768);
        exp_cg = 1'b0;
        exp_vg = 1'b0;
        if (!rs) begin
            if (cr && vr) begin
                if (cpu_wait_grants >= c_BURST) exp_cg = 1'b1;
                else exp_vg = 1'b1;
            end else begin
                exp_cg = cr;
                exp_vg = vr;
            end
        end
        chk("cpu_gnt", 32'(cpu_gnt), 32'(exp_cg));
        chk("vid_gnt", 32'(vid_gnt), 32'(exp_vg));
        chk("mem_load", 32'(mem_load), 32'(exp_cg && cw && (32'(ca) < 32'h6000)));
        if (exp_vg) begin
            chk("mem_address_vid", 32'(mem_address), 32'(vfull));
            chk("mem_in_vid", 32'(mem_in), 32'h0);
        end else begin
            chk("mem_address_cpu", 32'(mem_address), 32'(ca));
            if (exp_cg && cw) chk("mem_in_cpu", 32'(mem_in), 32'(cd));
        end
        if (exp_cg && !cw) cpu_q.push_back(mm[ca]);
        if (exp_vg) vid_q.push_back(mm[vfull]);
        if (exp_cg && cw && (32'(ca) >= 32'h6000)) werr_q.push_back(1);
        if (exp_cg && cw && (32'(ca) < 32'h6000)) mm[ca] = cd;
        if (rs || !cr || exp_cg) cpu_wait_grants = 0;
        else if (exp_vg) cpu_wait_grants = cpu_wait_grants + 1;
    endtask

    // Monitor: registered outputs of the cycle just closed, checked 1 ns after the edge.
    logic [15:0] last_c = 16'h0, last_v = 16'h0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
            chk("rst_vid_rdata", 32'(vid_rdata), 32'h0);
            last_c = 16'h0;
            last_v = 16'h0;
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_spurious", 32'(cpu_rvalid), 32'h0);
            else begin
                last_c = cpu_q.pop_front();
                chk("cpu_rdata", 32'(cpu_rdata), 32'(last_c));
            end
        end else begin
            if (cpu_q.size() != 0) begin
                chk("cpu_rvalid_missing", 32'(cpu_rvalid), 32'h1);
                void'(cpu_q.pop_front());
            end
            chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_c));
        end
        if (vid_rvalid) begin
            if (vid_q.size() == 0) chk("vid_rvalid_spurious", 32'(vid_rvalid), 32'h0);
            else begin
                last_v = vid_q.pop_front();
                chk("vid_rdata", 32'(vid_rdata), 32'(last_v));
            end
        end else begin
            if (vid_q.size() != 0) begin
                chk("vid_rvalid_missing", 32'(vid_rvalid), 32'h1);
                void'(vid_q.pop_front());
            end
            chk("vid_rdata_hold", 32'(vid_rdata), 32'(last_v));
        end
        chk("cpu_werr", 32'(cpu_werr), 32'(werr_q.size() != 0));
        if (werr_q.size() != 0) void'(werr_q.pop_front());
    end

    function automatic logic [14:0] rand_caddr();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: rand_caddr = 15'($urandom_range(0, 63));
            4, 5:       rand_caddr = 15'(32'h4000 + $urandom_range(0, 63));
            6:          rand_caddr = 15'(32'h6000 + $urandom_range(0, 3));
            default:    rand_caddr = 15'($urandom);
        endcase
    endfunction

    initial begin
        logic        ch, cw, vh, rs;
        logic [14:0] ca;
        logic [15:0] cd;
        logic [12:0] va;
        int          cpu_pct, vid_pct;

        for (int i = 0; i < 32768; i++) begin
            bmem[i] = 16'(i) ^ 16'h5A5A;
            mm[i]   = 16'(i) ^ 16'h5A5A;
        end

        cycle(1'b1, 1'b0, 15'h0, 16'h0, 1'b1, 13'h0, 1'b1);
        cycle(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 13'h0, 1'b0);

        cycle(1'b1, 1'b1, 15'h0010, 16'h1234, 1'b0, 13'h0, 1'b0);
        cycle(1'b1, 1'b0, 15'h0010, 16'h0000, 1'b0, 13'h0, 1'b0);
        cycle(1'b1, 1'b1, 15'h4003, 16'hBEEF, 1'b0, 13'h0, 1'b0);
        cycle(1'b0, 1'b0, 15'h0000, 16'h0000, 1'b1, 13'h0003, 1'b0);
        cycle(1'b1, 1'b1, 15'h6000, 16'hFFFF, 1'b0, 13'h0, 1'b0);
        cycle(1'b1, 1'b0, 15'h6000, 16'h0000, 1'b0, 13'h0, 1'b0);
        cycle(1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, 13'h0, 1'b0);

        // Continuous video with a held CPU read: CPU wins on cycles 4 and 9.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 15'h0011, 16'h0, 1'b1, 13'(i), 1'b0);
            chk("burst_pattern", 32'(cpu_gnt), 32'((i == 4) || (i == 9)));
        end
        // CPU request dropped mid-wait restarts its full wait.
        cycle(1'b1, 1'b0, 15'h0012, 16'h0, 1'b1, 13'h1, 1'b0);
        cycle(1'b1, 1'b0, 15'h0012, 16'h0, 1'b1, 13'h2, 1'b0);
        cycle(1'b0, 1'b0, 15'h0012, 16'h0, 1'b1, 13'h3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 15'h0012, 16'h0, 1'b1, 13'(i), 1'b0);
            chk("drop_restart", 32'(cpu_gnt), 32'(i == 4));
        end
        // Reset in a contested cycle, then first contested grant goes to video.
        cycle(1'b1, 1'b0, 15'h0013, 16'h0, 1'b1, 13'h5, 1'b1);
        cycle(1'b1, 1'b0, 15'h0013, 16'h0, 1'b1, 13'h5, 1'b0);
        chk("post_reset_vid", 32'(vid_gnt), 32'h1);

        ch = 1'b0; cw = 1'b0; ca = '0; cd = '0; vh = 1'b0; va = '0;
        cpu_pct = 50; vid_pct = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) begin
                cpu_pct = $urandom_range(10, 90);
                vid_pct = ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(0, 90);
            end
            if (!ch && $urandom_range(0, 99) < cpu_pct) begin
                ch = 1'b1;
                cw = $urandom_range(0, 1) == 1;
                ca = rand_caddr();
                cd = 16'($urandom);
            end else if (ch && $urandom_range(0, 19) == 0) begin
                ch = 1'b0;
            end
            if (!vh && $urandom_range(0, 99) < vid_pct) begin
                vh = 1'b1;
                va = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, 63));
            end
            rs = $urandom_range(0, 149) == 0;
            cycle(ch, cw, ca, cd, vh, va, rs);
            if (exp_cg) ch = 1'b0;
            if (exp_vg) vh = 1'b0;
        end
        cycle(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 13'h0, 1'b0);
        cycle(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 13'h0, 1'b0);

        for (int i = 0; i < 128; i++) begin
            chk("mem_low", 32'(bmem[i]), 32'(mm[i]));
        end
        for (int i = 32'h4000; i < 32'h4040; i++) begin
            chk("mem_screen", 32'(bmem[i]), 32'(mm[i]));
        end
        for (int i = 32'h6000; i < 32'h6004; i++) begin
            chk("mem_kbd", 32'(bmem[i]), 32'(mm[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
